// File: rtl/cheese_if.sv
// Position/score bundle between the cheese controller, the player logic, the drawer and the HUD.
// master = game side that drives ticks and player position; slave = cheese_ctl.
interface cheese_if;
  logic        frame_tick;
  logic        game_en;
  logic [10:0] player_x;
  logic [10:0] player_y;
  logic [10:0] cheese_x;
  logic [10:0] cheese_y;
  logic        cheese_vis;
  logic        collected;
  logic [7:0]  score;

  modport master (
    output frame_tick, game_en, player_x, player_y,
    input  cheese_x, cheese_y, cheese_vis, collected, score
  );

  modport slave (
    input  frame_tick, game_en, player_x, player_y,
    output cheese_x, cheese_y, cheese_vis, collected, score
  );
endinterface

// File: rtl/cheese_ctl.sv
// Cheese sprite sequencer: pseudo-random spawn, pickup detection on frame_tick,
// saturating score and frame-counted respawn delay.
module cheese_ctl #(
   parameter int CHEESE_W       = 32,
   parameter int CHEESE_H       = 24,
   parameter int PLAYER_W       = 48,
   parameter int PLAYER_H       = 64,
   parameter int X_MIN          = 64,
   parameter int X_BITS         = 9,
   parameter int Y_LVL0         = 600,
   parameter int Y_LVL1         = 450,
   parameter int Y_LVL2         = 300,
   parameter int Y_LVL3         = 150,
   parameter int RESPAWN_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst,
   cheese_if.slave    bus_if,
   output logic [1:0] dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SPAWN  = 2'd1,
      S_ACTIVE = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESPAWN_FRAMES - 1);
   localparam logic [11:0] CW12 = 12'(CHEESE_W);
   localparam logic [11:0] CH12 = 12'(CHEESE_H);
   localparam logic [11:0] PW12 = 12'(PLAYER_W);
   localparam logic [11:0] PH12 = 12'(PLAYER_H);

   state_t           state_q, state_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [10:0]      x_q, x_d;
   logic [10:0]      y_q, y_d;
   logic             vis_q, vis_d;
   logic             coll_q, coll_d;
   logic [7:0]       score_q, score_d;

   logic [10:0]      spawn_x;
   logic [10:0]      spawn_y;
   logic             hit;
   logic [11:0]      px, py, cx, cy;

   // Taps 16,14,13,11; a nonzero seed keeps the register out of the all-zero lockup.
   assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign spawn_x = 11'(X_MIN) + 11'(lfsr_q[X_BITS-1:0]);

   always_comb begin
      spawn_y = 11'(Y_LVL0);
      case (lfsr_q[15:14])
         2'd0:    spawn_y = 11'(Y_LVL0);
         2'd1:    spawn_y = 11'(Y_LVL1);
         2'd2:    spawn_y = 11'(Y_LVL2);
         default: spawn_y = 11'(Y_LVL3);
      endcase
   end

   // Strict inequalities: boxes that only share an edge do not count as touching.
   assign px  = {1'b0, bus_if.player_x};
   assign py  = {1'b0, bus_if.player_y};
   assign cx  = {1'b0, x_q};
   assign cy  = {1'b0, y_q};
   assign hit = (px < cx + CW12) && (cx < px + PW12) &&
                (py < cy + CH12) && (cy < py + PH12);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      vis_d   = vis_q;
      coll_d  = 1'b0;
      score_d = score_q;
      if (!bus_if.game_en) begin
         state_d = S_IDLE;
         vis_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               vis_d   = 1'b0;
               score_d = 8'd0;
               state_d = S_SPAWN;
            end
            S_SPAWN: begin
               x_d     = spawn_x;
               y_d     = spawn_y;
               vis_d   = 1'b1;
               state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
               if (bus_if.frame_tick && hit) begin
                  coll_d  = 1'b1;
                  score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                  vis_d   = 1'b0;
                  cnt_d   = CNT_LOAD;
                  state_d = S_WAIT;
               end
            end
            default: begin
               if (bus_if.frame_tick) begin
                  if (cnt_q == '0) state_d = S_SPAWN;
                  else             cnt_d   = cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lfsr_q  <= 16'hACE1;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         vis_q   <= 1'b0;
         coll_q  <= 1'b0;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vis_q   <= vis_d;
         coll_q  <= coll_d;
         score_q <= score_d;
      end
   end

   assign bus_if.cheese_x   = x_q;
   assign bus_if.cheese_y   = y_q;
   assign bus_if.cheese_vis = vis_q;
   assign bus_if.collected  = coll_q;
   assign bus_if.score      = score_q;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_cheese_ctl.sv
// Bench for cheese_ctl: overlap-boundary vector table, respawn timing, tick gating,
// score saturation, game_en priority and mid-WAIT reset.
module tb_cheese_ctl;
  localparam int RESPAWN = 60;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SPAWN = 2'd1, ST_ACTIVE = 2'd2, ST_WAIT = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  cheese_if bus ();

  cheese_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .bus_if      (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference LFSR written as a masked parity of the tap bits.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int exp_score = 0;
  int cx_m = 0;
  int cy_m = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each pickup pulse must match a queued expected score.
  always @(negedge clk) begin
    if (bus.collected === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_collected: got 1 expected 0 (score %0d) at %0t", bus.score, $time);
      end else begin
        check("collect_score", int'(bus.score), int'(exp_q.pop_front()));
      end
    end
  end

  function automatic int ylvl(input logic [1:0] s);
    case (s)
      2'd0:    return 600;
      2'd1:    return 450;
      2'd2:    return 300;
      default: return 150;
    endcase
  endfunction

  // Called at the negedge inside the SPAWN cycle.
  task automatic spawn_check();
    logic [15:0] l;
    l    = m_lfsr;
    cx_m = 64 + int'(l[8:0]);
    cy_m = ylvl(l[15:14]);
    check("spawn_state", int'(dbg_state), int'(ST_SPAWN));
    check("spawn_vis_pre", int'(bus.cheese_vis), 0);
    @(negedge clk);
    check("spawn_vis", int'(bus.cheese_vis), 1);
    check("spawn_x", int'(bus.cheese_x), cx_m);
    check("spawn_y", int'(bus.cheese_y), cy_m);
    check("spawn_active", int'(dbg_state), int'(ST_ACTIVE));
  endtask

  task automatic tick_pulse();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic pickup();
    bus.player_x = 11'(cx_m);
    bus.player_y = 11'(cy_m);
    if (exp_score < 255) exp_score++;
    exp_q.push_back(8'(exp_score));
    tick_pulse();
    #1;
    check("pickup_seen", exp_q.size(), 0);
    check("pickup_vis", int'(bus.cheese_vis), 0);
    check("pickup_score", int'(bus.score), exp_score);
    check("pickup_wait", int'(dbg_state), int'(ST_WAIT));
  endtask

  task automatic respawn();
    for (int i = 0; i < RESPAWN - 1; i++) begin
      tick_pulse();
      @(negedge clk);
    end
    check("respawn_vis_held", int'(bus.cheese_vis), 0);
    check("respawn_still_wait", int'(dbg_state), int'(ST_WAIT));
    tick_pulse();
    spawn_check();
  endtask

  typedef struct {
    string name;
    int    dx;
    int    dy;
    bit    hit;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"right_edge_touch", 32,   0, 1'b0};
    vecs[1] = '{"left_edge_touch", -48,   0, 1'b0};
    vecs[2] = '{"bottom_edge_touch", 0,  24, 1'b0};
    vecs[3] = '{"top_edge_touch",    0, -64, 1'b0};
    vecs[4] = '{"far_away",        300, 200, 1'b0};
    vecs[5] = '{"right_overlap1",   31,   0, 1'b1};
    vecs[6] = '{"left_overlap1",   -47,   0, 1'b1};
    vecs[7] = '{"bottom_overlap1",   0,  23, 1'b1};
    vecs[8] = '{"top_overlap1",      0, -63, 1'b1};
    vecs[9] = '{"corner_overlap",   31,  23, 1'b1};

    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.game_en    = 1'b0;
    bus.player_x   = '0;
    bus.player_y   = '0;
    repeat (3) @(negedge clk);
    check("rst_x", int'(bus.cheese_x), 0);
    check("rst_y", int'(bus.cheese_y), 0);
    check("rst_vis", int'(bus.cheese_vis), 0);
    check("rst_coll", int'(bus.collected), 0);
    check("rst_score", int'(bus.score), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_hold", int'(dbg_state), int'(ST_IDLE));

    // Start: SPAWN for one clk, visible on the second.
    bus.game_en = 1'b1;
    @(negedge clk);
    check("start_score", int'(bus.score), 0);
    spawn_check();

    // Overlap boundary table.
    foreach (vecs[i]) begin
      bus.player_x = 11'(cx_m + vecs[i].dx);
      bus.player_y = 11'(cy_m + vecs[i].dy);
      if (vecs[i].hit) begin
        exp_score++;
        exp_q.push_back(8'(exp_score));
      end
      tick_pulse();
      #1;
      check({vecs[i].name, "_seen"}, exp_q.size(), 0);
      check({vecs[i].name, "_vis"}, int'(bus.cheese_vis), vecs[i].hit ? 0 : 1);
      check({vecs[i].name, "_score"}, int'(bus.score), exp_score);
      @(negedge clk);
      if (vecs[i].hit) respawn();
    end

    // Overlap held without frame_tick: nothing happens.
    bus.player_x = 11'(cx_m);
    bus.player_y = 11'(cy_m);
    repeat (1000) @(negedge clk);
    check("notick_score", int'(bus.score), exp_score);
    check("notick_vis", int'(bus.cheese_vis), 1);
    pickup();
    respawn();

    // Drive the score to saturation, then one more pickup.
    while (exp_score < 255) begin
      pickup();
      respawn();
    end
    pickup();
    check("sat_score", int'(bus.score), 255);
    respawn();

    // game_en drop in the same clk as a hit tick.
    bus.player_x   = 11'(cx_m);
    bus.player_y   = 11'(cy_m);
    bus.frame_tick = 1'b1;
    bus.game_en    = 1'b0;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    #1;
    check("gate_state", int'(dbg_state), int'(ST_IDLE));
    check("gate_vis", int'(bus.cheese_vis), 0);
    check("gate_score", int'(bus.score), 255);
    check("gate_x_held", int'(bus.cheese_x), cx_m);
    check("gate_y_held", int'(bus.cheese_y), cy_m);
    repeat (3) begin
      @(negedge clk);
      tick_pulse();
    end
    check("gate_idle_hold", int'(dbg_state), int'(ST_IDLE));

    // Restart clears the score.
    @(negedge clk);
    bus.game_en = 1'b1;
    @(negedge clk);
    exp_score = 0;
    check("restart_score", int'(bus.score), 0);
    spawn_check();
    pickup();

    // Reset in the middle of WAIT.
    repeat (3) begin
      @(negedge clk);
      tick_pulse();
    end
    bus.game_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_x", int'(bus.cheese_x), 0);
    check("midrst_y", int'(bus.cheese_y), 0);
    check("midrst_vis", int'(bus.cheese_vis), 0);
    check("midrst_coll", int'(bus.collected), 0);
    check("midrst_score", int'(bus.score), 0);
    check("midrst_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
